// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - write/read handshake and status bundle for sync_fifo_param
// Shared by the FIFO (slave) and its user (master).
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              err_clr;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en, err_clr,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, err_clr,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds and sticky errors
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_param_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full, empty, wr_acc, rd_acc;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_C);
    // Acceptance looks only at this cycle's registered flags, never at the other port.
    wr_acc   = bus.wr_en && !full;
    rd_acc   = bus.rd_en && !empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_ONE;
    end
    overflow_d  = (bus.wr_en && full)  || (overflow_q  && !bus.err_clr);
    underflow_d = (bus.rd_en && empty) || (underflow_q && !bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_acc) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.dout       = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.dout_valid = !empty;
`else
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  always_comb begin
    dout_d       = rd_acc ? mem_q[rd_ptr_q] : dout_q;
    dout_valid_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
